// File: rtl/arith_crypt_pkg.sv
// Shared definitions for the arithmetic cipher sequencer: default sizing,
// command opcodes and the controller state set.
package arith_crypt_pkg;

   localparam int DEF_NKEY    = 4;
   localparam int DEF_NBLK    = 4;
   localparam int DEF_TIMEOUT = 255;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ENC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LKEY  = 3'd1,
      ST_LBLK  = 3'd2,
      ST_START = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DRAIN = 3'd5
   } state_e;

endpackage

// File: rtl/arith_crypt_seq_if.sv
// Command, byte-in, engine and byte-out signals of the sequencer in one bundle.
interface arith_crypt_seq_if
   import arith_crypt_pkg::*;
#(
   parameter int NKEY = DEF_NKEY,
   parameter int NBLK = DEF_NBLK
) ();

   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd_op;
   logic                in_valid;
   logic                in_ready;
   logic [7:0]          in_data;
   logic                eng_start;
   logic                eng_mode;
   logic [8*NKEY-1:0]   eng_key;
   logic [8*NBLK-1:0]   eng_blk;
   logic                eng_done;
   logic [8*NBLK-1:0]   eng_result;
   logic                out_valid;
   logic                out_ready;
   logic [7:0]          out_data;
   logic                busy;
   logic                err;

   modport slave (
      input  cmd_valid, cmd_op, in_valid, in_data, eng_done, eng_result, out_ready,
      output cmd_ready, in_ready, eng_start, eng_mode, eng_key, eng_blk,
             out_valid, out_data, busy, err
   );

   modport master (
      output cmd_valid, cmd_op, in_valid, in_data, eng_done, eng_result, out_ready,
      input  cmd_ready, in_ready, eng_start, eng_mode, eng_key, eng_blk,
             out_valid, out_data, busy, err
   );

endinterface

// File: rtl/arith_crypt_byte_shreg.sv
// Byte shift register with a transfer counter: serial fill at the LSB end,
// parallel load, and MSB-first unload by shifting left one byte.
module arith_crypt_byte_shreg #(
   parameter int NB = 4,
   parameter int CW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            cnt_clr,
   input  logic            shift_in,
   input  logic            shift_out,
   input  logic            load,
   input  logic [7:0]      din,
   input  logic [8*NB-1:0] pdin,
   output logic [8*NB-1:0] q,
   output logic [CW-1:0]   cnt
);

   logic [7:0]      fill;
   logic [8*NB-1:0] shifted;

   assign fill = shift_in ? din : 8'h00;

   if (NB > 1) begin : g_wide
      assign shifted = {q[8*NB-9:0], fill};
   end else begin : g_narrow
      assign shifted = fill;
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q   <= '0;
         cnt <= '0;
      end else if (clr) begin
         q   <= '0;
         cnt <= '0;
      end else if (load) begin
         q   <= pdin;
         cnt <= '0;
      end else begin
         if (shift_in || shift_out) q <= shifted;
         if (cnt_clr)                      cnt <= '0;
         else if (shift_in || shift_out)   cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/arith_crypt_seq.sv
// Sequencer that loads a key and a block byte-serially, runs an external
// arithmetic cipher engine once, and streams the result back MSB first.
module arith_crypt_seq
   import arith_crypt_pkg::*;
#(
   parameter int NKEY    = DEF_NKEY,
   parameter int NBLK    = DEF_NBLK,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic              clk,
   input logic              rst,
   arith_crypt_seq_if.slave bus
);

   localparam int            CW       = $clog2(((NKEY > NBLK) ? NKEY : NBLK) + 1);
   localparam logic [CW-1:0] KEY_LAST = CW'(NKEY - 1);
   localparam logic [CW-1:0] BLK_LAST = CW'(NBLK - 1);
   localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT - 1);

   localparam logic [2:0] IDLE  = ST_IDLE;
   localparam logic [2:0] LKEY  = ST_LKEY;
   localparam logic [2:0] LBLK  = ST_LBLK;
   localparam logic [2:0] START = ST_START;
   localparam logic [2:0] WAIT  = ST_WAIT;
   localparam logic [2:0] DRAIN = ST_DRAIN;

   logic [2:0]         state;
   logic               key_valid;
   logic               mode;
   logic               err_q;
   logic [7:0]         timer;
   logic               cmd_acc;
   logic               in_acc;
   logic [CW-1:0]      key_cnt;
   logic [CW-1:0]      blk_cnt;
   logic [CW-1:0]      res_cnt;
   logic [8*NBLK-1:0]  res_q;

   assign cmd_acc = bus.cmd_valid && (state == IDLE);
   assign in_acc  = bus.in_valid && bus.in_ready;

   arith_crypt_byte_shreg #(.NB(NKEY), .CW(CW)) u_key (
      .clk(clk), .rst(rst),
      .clr(cmd_acc && (bus.cmd_op == OP_CLR)),
      .cnt_clr(cmd_acc && (bus.cmd_op == OP_LOAD)),
      .shift_in(in_acc && (state == LKEY)), .shift_out(1'b0), .load(1'b0),
      .din(bus.in_data), .pdin('0), .q(bus.eng_key), .cnt(key_cnt)
   );

   arith_crypt_byte_shreg #(.NB(NBLK), .CW(CW)) u_blk (
      .clk(clk), .rst(rst), .clr(1'b0),
      .cnt_clr(cmd_acc && key_valid && ((bus.cmd_op == OP_ENC) || (bus.cmd_op == OP_DEC))),
      .shift_in(in_acc && (state == LBLK)), .shift_out(1'b0), .load(1'b0),
      .din(bus.in_data), .pdin('0), .q(bus.eng_blk), .cnt(blk_cnt)
   );

   arith_crypt_byte_shreg #(.NB(NBLK), .CW(CW)) u_res (
      .clk(clk), .rst(rst), .clr(1'b0), .cnt_clr(1'b0), .shift_in(1'b0),
      .shift_out((state == DRAIN) && bus.out_ready),
      .load((state == WAIT) && bus.eng_done),
      .din(8'h00), .pdin(bus.eng_result), .q(res_q), .cnt(res_cnt)
   );

   // A done arriving in the final wait cycle takes priority over the timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         key_valid <= 1'b0;
         mode      <= 1'b0;
         err_q     <= 1'b0;
         timer     <= 8'h00;
      end else begin
         err_q <= 1'b0;
         case (state)
            IDLE: if (cmd_acc) begin
               case (bus.cmd_op)
                  OP_LOAD: begin
                     state     <= LKEY;
                     key_valid <= 1'b0;
                  end
                  OP_ENC, OP_DEC: begin
                     if (key_valid) begin
                        state <= LBLK;
                        mode  <= (bus.cmd_op == OP_DEC);
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
                  default: key_valid <= 1'b0;
               endcase
            end
            LKEY: if (in_acc && (key_cnt == KEY_LAST)) begin
               state     <= IDLE;
               key_valid <= 1'b1;
            end
            LBLK: if (in_acc && (blk_cnt == BLK_LAST)) state <= START;
            START: begin
               state <= WAIT;
               timer <= 8'h00;
            end
            WAIT: begin
               if (bus.eng_done) begin
                  state <= DRAIN;
               end else if (timer == TO_LAST) begin
                  state <= IDLE;
                  err_q <= 1'b1;
               end else begin
                  timer <= timer + 8'h01;
               end
            end
            DRAIN: if (bus.out_ready && (res_cnt == BLK_LAST)) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = (state == IDLE);
   assign bus.in_ready  = (state == LKEY) || (state == LBLK);
   assign bus.eng_start = (state == START);
   assign bus.eng_mode  = mode;
   assign bus.out_valid = (state == DRAIN);
   assign bus.out_data  = res_q[8*NBLK-1 -: 8];
   assign bus.busy      = (state != IDLE);
   assign bus.err       = err_q;

endmodule

// File: tb/tb_arith_crypt_seq.sv
// Directed bench for arith_crypt_seq: a transaction-level model (key/block
// values, expected output byte queue) plus literal checks at key cycles.
module tb_arith_crypt_seq;
   import arith_crypt_pkg::*;

   localparam int NKEY    = 4;
   localparam int NBLK    = 4;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;

   arith_crypt_seq_if #(.NKEY(NKEY), .NBLK(NBLK)) bus ();

   arith_crypt_seq #(.NKEY(NKEY), .NBLK(NBLK), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int starts   = 0;
   int errs     = 0;

   logic [8*NKEY-1:0] m_key  = '0;
   logic [8*NBLK-1:0] m_blk  = '0;
   logic              m_mode = 1'b0;
   logic [7:0]        exp_q[$];
   logic              hold_valid = 1'b0;
   logic [7:0]        held = 8'h00;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_bound(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: output stream, key/block assembly and mode at engine start.
   always @(negedge clk) begin
      if (rst) begin
         hold_valid = 1'b0;
      end else begin
         check("cmd_ready_vs_busy", bus.cmd_ready, !bus.busy);
         if (bus.err) errs++;
         if (bus.eng_start) begin
            starts++;
            check("start_key", bus.eng_key, m_key);
            check("start_blk", bus.eng_blk, m_blk);
            check("start_mode", bus.eng_mode, m_mode);
         end
         if (bus.out_valid) begin
            if (hold_valid) check("out_hold", bus.out_data, held);
            if (bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL out_extra: got %0h, expected no transfer", bus.out_data);
               end else begin
                  check("out_byte", bus.out_data, exp_q.pop_front());
               end
               hold_valid = 1'b0;
            end else begin
               hold_valid = 1'b1;
               held       = bus.out_data;
            end
         end else begin
            hold_valid = 1'b0;
         end
      end
   end

   task automatic send_cmd(input logic [1:0] op);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      while (!bus.cmd_ready && n < 50) begin tick(); n++; end
      if (!bus.cmd_ready) fail_bound("cmd_ready_wait");
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit to_key);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && n < 50) begin tick(); n++; end
      if (!bus.in_ready) fail_bound("in_ready_wait");
      tick();
      bus.in_valid = 1'b0;
      if (to_key) m_key = (m_key << 8) | (8*NKEY)'(b);
      else        m_blk = (m_blk << 8) | (8*NBLK)'(b);
   endtask

   task automatic load_key(input logic [8*NKEY-1:0] k);
      send_cmd(OP_LOAD);
      for (int i = NKEY - 1; i >= 0; i--) send_byte(k[8*i +: 8], 1'b1);
   endtask

   task automatic load_block(input logic [1:0] op, input logic [8*NBLK-1:0] b);
      m_mode = (op == OP_DEC);
      send_cmd(op);
      for (int i = NBLK - 1; i >= 0; i--) send_byte(b[8*i +: 8], 1'b0);
   endtask

   task automatic push_result(input logic [8*NBLK-1:0] r);
      for (int i = NBLK - 1; i >= 0; i--) exp_q.push_back(r[8*i +: 8]);
   endtask

   task automatic drain_all();
      int n = 0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 20) begin tick(); n++; end
      bus.out_ready = 1'b0;
      if (exp_q.size() != 0) fail_bound("drain_wait");
      check("drain_idle", bus.busy, 1'b0);
   endtask

   initial begin
      int k;
      int errs_before;
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 2'b00;
      bus.in_valid   = 1'b0;
      bus.in_data    = 8'h00;
      bus.eng_done   = 1'b0;
      bus.eng_result = '0;
      bus.out_ready  = 1'b0;

      #2 rst = 1'b1;
      #2;
      check("rst_cmd_ready", bus.cmd_ready, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_eng_start", bus.eng_start, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_err", bus.err, 1'b0);
      check("rst_eng_key", bus.eng_key, 32'h0);
      check("rst_eng_blk", bus.eng_blk, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Encrypt with no key loaded
      send_cmd(OP_ENC);
      check("nokey_err", bus.err, 1'b1);
      check("nokey_idle", bus.busy, 1'b0);
      tick();
      check("nokey_err_pulse", bus.err, 1'b0);
      check("nokey_no_start", starts, 0);

      // Basic encrypt with output back-pressure
      load_key(32'h11223344);
      check("key_loaded", bus.eng_key, 32'h11223344);
      check("key_idle", bus.busy, 1'b0);
      load_block(OP_ENC, 32'hAABBCCDD);
      check("start_latency", bus.eng_start, 1'b1);
      check("blk_literal", bus.eng_blk, 32'hAABBCCDD);
      check("mode_enc", bus.eng_mode, 1'b0);
      tick();
      check("start_one_cycle", bus.eng_start, 1'b0);
      tick();
      check("pre_done_no_valid", bus.out_valid, 1'b0);
      bus.eng_done   = 1'b1;
      bus.eng_result = 32'h01020304;
      push_result(32'h01020304);
      tick();
      bus.eng_done = 1'b0;
      check("done_latency", bus.out_valid, 1'b1);
      check("first_byte", bus.out_data, 8'h01);
      repeat (3) tick();
      check("stall_hold", bus.out_data, 8'h01);
      drain_all();
      check("one_start", starts, 1);

      // Timeout with no engine response
      load_block(OP_DEC, 32'h5AA50FF0);
      k = 0;
      while (!bus.err && k < 40) begin tick(); k++; end
      check("timeout_latency", k, 17);
      check("timeout_idle", bus.busy, 1'b0);
      tick();
      check("timeout_err_pulse", bus.err, 1'b0);

      // Done coincident with the final wait cycle
      errs_before = errs;
      load_block(OP_ENC, 32'h13579BDF);
      repeat (16) tick();
      check("coinc_still_wait", bus.busy, 1'b1);
      bus.eng_done   = 1'b1;
      bus.eng_result = 32'hDEADBEEF;
      push_result(32'hDEADBEEF);
      tick();
      bus.eng_done = 1'b0;
      check("coinc_captured", bus.out_valid, 1'b1);
      check("coinc_no_err", bus.err, 1'b0);
      drain_all();
      check("coinc_err_count", errs, errs_before);

      // Clear key, then decrypt
      load_key(32'h01020304);
      send_cmd(OP_CLR);
      m_key = '0;
      check("clr_key_zero", bus.eng_key, 32'h0);
      send_cmd(OP_DEC);
      check("clr_dec_err", bus.err, 1'b1);
      check("clr_dec_idle", bus.busy, 1'b0);
      tick();
      check("clr_err_pulse", bus.err, 1'b0);

      // Reset in the middle of a block load
      load_key(32'h11223344);
      m_mode = 1'b0;
      send_cmd(OP_ENC);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_cmd_ready", bus.cmd_ready, 1'b1);
      check("midrst_in_ready", bus.in_ready, 1'b0);
      check("midrst_key", bus.eng_key, 32'h0);
      check("midrst_blk", bus.eng_blk, 32'h0);
      @(negedge clk);
      check("midrst_no_start", bus.eng_start, 1'b0);
      tick();
      check("midrst_hold_start", bus.eng_start, 1'b0);
      rst   = 1'b0;
      m_key = '0;
      m_blk = '0;
      load_key(32'hCAFEF00D);
      load_block(OP_ENC, 32'h12345678);
      tick();
      tick();
      bus.eng_done   = 1'b1;
      bus.eng_result = 32'h89ABCDEF;
      push_result(32'h89ABCDEF);
      tick();
      bus.eng_done = 1'b0;
      check("after_rst_valid", bus.out_valid, 1'b1);
      check("after_rst_byte", bus.out_data, 8'h89);
      drain_all();

      check("total_starts", starts, 4);
      check("total_errs", errs, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/arith_crypt_seq.md
ARITH_CRYPT_SEQ -- requirements
Module: arith_crypt_seq

Interface
REQ-001 SHALL have parameter NKEY, default 4, number of key bytes.
REQ-002 SHALL have parameter NBLK, default 4, number of block bytes.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum engine wait cycles (8-bit).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-007 cmd_op  input  2  00 load key, 01 encrypt, 10 decrypt, 11 clear key.
REQ-008 in_valid / in_ready  input / output  1 / 1  byte input handshake.
REQ-009 in_data  input  8  key or block byte, most significant byte first.
REQ-010 eng_start  output  1  one-cycle engine start pulse.
REQ-011 eng_mode  output  1  0 = encrypt, 1 = decrypt; stable from eng_start until done or timeout.
REQ-012 eng_key / eng_blk  output  8*NKEY / 8*NBLK  operands to arithmetic cipher engine.
REQ-013 eng_done  input  1  engine completion pulse.
REQ-014 eng_result  input  8*NBLK  engine result; valid in the eng_done cycle.
REQ-015 out_valid / out_ready / out_data  output / input / output  1 / 1 / 8  result byte stream, MSB first.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 err  output  1  one-cycle pulse on protocol error or timeout.

Function
REQ-018 FSM states SHALL be IDLE, LKEY, LBLK, START, WAIT, DRAIN.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-020 op 00: IDLE->LKEY, byte counter cleared, key_valid cleared.
REQ-021 op 01/10 with key_valid=1: IDLE->LBLK, mode latched; with key_valid=0: stay IDLE, err pulse next cycle.
REQ-022 op 11: key register and key_valid cleared, stay IDLE.
REQ-023 in_ready SHALL be 1 only in LKEY/LBLK; each accepted byte shifts into the LSB end of the target register (first byte ends up MSB).
REQ-024 LKEY: after NKEY accepted bytes -> IDLE, key_valid=1.
REQ-025 LBLK: after NBLK accepted bytes -> START.
REQ-026 START: eng_start=1 for exactly one cycle -> WAIT, wait timer cleared; eng_done in START ignored.
REQ-027 WAIT: eng_done captures eng_result -> DRAIN; timer reaching TIMEOUT without done -> IDLE with err pulse; done and timeout in the same cycle: done wins.
REQ-028 Latency: last block byte accepted in cycle N -> eng_start in N+1; eng_done in cycle M -> out_valid in M+1.
REQ-029 DRAIN: out_valid=1, out_data = MSB of result register; on out_ready, shift left one byte; after NBLK transfers -> IDLE.
REQ-030 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-031 Byte counter SHALL be sized ceil(log2(max(NKEY,NBLK)+1)) bits; no wrap-around is permitted.
REQ-032 eng_key SHALL always reflect the key register; eng_blk the block register.

Reset
REQ-033 On rst: state IDLE, all registers and counters 0, key_valid 0.
REQ-034 On rst: cmd_ready=1 and all other outputs 0, including eng_start, out_valid, busy and err.
REQ-035 rst asserted mid-operation SHALL abort immediately with no further engine pulse.

Structure
REQ-036 Package arith_crypt_pkg SHALL hold the state enum, opcode constants and default NKEY/NBLK/TIMEOUT.
REQ-037 One sub-module SHALL be used: arith_crypt_byte_shreg (parameterised byte shift register with load counter), instantiated for key, block and result.

Verification
REQ-038 Load key 11 22 33 44, encrypt block AA BB CC DD -> eng_key=0x11223344, eng_blk=0xAABBCCDD, eng_mode=0, one eng_start pulse.
REQ-039 Engine returns 0x01020304 with out_ready held low 3 cycles -> out_data stays 0x01, then streams 01 02 03 04, then IDLE.
REQ-040 Encrypt command issued after reset (no key) -> err pulse, no eng_start, state stays IDLE.
REQ-041 No eng_done for TIMEOUT cycles -> err pulse, return to IDLE; eng_done coincident with timeout -> result captured, no err.
REQ-042 rst asserted after 2 of 4 block bytes -> all outputs at reset values next edge; a new full sequence then succeeds.
REQ-043 Clear-key command after a load, then decrypt command -> err pulse, key output 0.
